// File: rtl/mlab_sr_pkg.sv
// Shared constants, FSM state type and parity helper for the MLAB shift-register writer.
package mlab_sr_pkg;

    localparam int PAY_WIDTH  = 19;
    localparam int WORD_WIDTH = PAY_WIDTH + 1;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int RD_LAT     = 2;
    localparam int FILL_MAX   = DEPTH - 1;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } fsm_state_e;

    // Parity bit that makes the XOR of the full stored word equal 1.
    function automatic logic odd_parity(input logic [PAY_WIDTH-1:0] payload);
        return ~^payload;
    endfunction

endpackage

// File: rtl/mlab_sr_writer_if.sv
// Bus between the payload source and the MLAB writer, plus the storage-facing outputs.
// Optional PARITY_INJECT_EN adds the inject_err input.
interface mlab_sr_writer_if;
    import mlab_sr_pkg::*;

    // Handshake: a word transfers on any rising clk edge where ena and din_valid are
    // both high; there is no backpressure, the writer always accepts.
    logic                  ena;
    logic [PAY_WIDTH-1:0]  din;
    logic                  din_valid;
    logic [ADDR_WIDTH-1:0] delay;
    logic                  delay_load;
`ifdef PARITY_INJECT_EN
    logic                  inject_err;
`endif
    logic [WORD_WIDTH-1:0] mlab_din;
    logic [ADDR_WIDTH-1:0] mlab_wraddr;
    logic                  mlab_we;
    logic [ADDR_WIDTH-1:0] mlab_rdaddr;
    logic                  primed;
    fsm_state_e            state;

    modport master (
`ifdef PARITY_INJECT_EN
        output inject_err,
`endif
        output ena, din, din_valid, delay, delay_load,
        input  mlab_din, mlab_wraddr, mlab_we, mlab_rdaddr, primed, state
    );

    modport slave (
`ifdef PARITY_INJECT_EN
        input  inject_err,
`endif
        input  ena, din, din_valid, delay, delay_load,
        output mlab_din, mlab_wraddr, mlab_we, mlab_rdaddr, primed, state
    );

endinterface

// File: rtl/mlab_sr_addr_gen.sv
// Circular write pointer, latched tap distance and registered read address
// (write pointer minus delay, modulo the storage depth).
module mlab_sr_addr_gen
    import mlab_sr_pkg::*;
(
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  ena,
    input  logic                  advance,
    input  logic                  delay_load,
    input  logic [ADDR_WIDTH-1:0] delay,
    output logic [ADDR_WIDTH-1:0] wr_ptr,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    output logic [ADDR_WIDTH-1:0] delay_q
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr  <= '0;
            rdaddr  <= '0;
            delay_q <= ADDR_WIDTH'(1);
        end else if (ena) begin
            if (advance) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // Natural 5-bit wrap gives the modular subtract for free.
            rdaddr <= wr_ptr - delay_q;
            if (delay_load) begin
                delay_q <= (delay == '0) ? ADDR_WIDTH'(1) : delay;
            end
        end
    end

endmodule

// File: rtl/mlab_sr_writer.sv
// Write-side controller for the 20-bit x 32-deep MLAB delay line: parity append,
// write-enable alignment and FILL/RUN priming FSM. Optional macro: PARITY_INJECT_EN.
module mlab_sr_writer
    import mlab_sr_pkg::*;
(
    input  logic             clk,
    input  logic             arst_n,
    mlab_sr_writer_if.slave  bus
);

    logic                  accepted;
    logic                  parity;
    logic                  we_pend;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rdaddr;
    logic [ADDR_WIDTH-1:0] delay_q;
    logic [ADDR_WIDTH-1:0] fill_cnt;
    logic [ADDR_WIDTH:0]   fill_sum;
    logic [ADDR_WIDTH-1:0] fill_target;
    fsm_state_e            state;
    fsm_state_e            state_next;

    assign accepted = bus.ena & bus.din_valid;

`ifdef PARITY_INJECT_EN
    assign parity = odd_parity(bus.din) ^ bus.inject_err;
`else
    assign parity = odd_parity(bus.din);
`endif

    mlab_sr_addr_gen u_addr_gen (
        .clk        (clk),
        .arst_n     (arst_n),
        .ena        (bus.ena),
        .advance    (accepted),
        .delay_load (bus.delay_load),
        .delay      (bus.delay),
        .wr_ptr     (wr_ptr),
        .rdaddr     (rdaddr),
        .delay_q    (delay_q)
    );

    assign bus.mlab_rdaddr = rdaddr;

    // Storage latches data/address on its own input register, so we trails by one ena-cycle.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            bus.mlab_din    <= '0;
            bus.mlab_wraddr <= '0;
            we_pend         <= 1'b0;
            bus.mlab_we     <= 1'b0;
        end else if (bus.ena) begin
            we_pend     <= accepted;
            bus.mlab_we <= we_pend;
            if (accepted) begin
                bus.mlab_din    <= {parity, bus.din};
                bus.mlab_wraddr <= wr_ptr;
            end
        end
    end

    // The fill counter saturates at 31, so long delays prime at the saturation point.
    assign fill_sum    = {1'b0, delay_q} + (ADDR_WIDTH + 1)'(RD_LAT);
    assign fill_target = (fill_sum > (ADDR_WIDTH + 1)'(FILL_MAX)) ?
                         ADDR_WIDTH'(FILL_MAX) : fill_sum[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            fill_cnt <= '0;
        end else if (bus.ena) begin
            if (bus.delay_load) begin
                fill_cnt <= {{(ADDR_WIDTH - 1){1'b0}}, accepted};
            end else if (state == FILL && accepted && fill_cnt != ADDR_WIDTH'(FILL_MAX)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= FILL;
        end else if (bus.ena) begin
            state <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        if (bus.delay_load) begin
            state_next = FILL;
        end else begin
            case (state)
                FILL:    if (fill_cnt == fill_target) state_next = RUN;
                RUN:     state_next = RUN;
                default: state_next = FILL;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        bus.primed = 1'b0;
        bus.state  = state;
        if (state == RUN) begin
            bus.primed = 1'b1;
        end
    end

endmodule

// File: tb/tb_mlab_sr_writer.sv
// Scoreboard bench for mlab_sr_writer: the driver feeds a word-level model, a monitor
// mimics the storage input register and checks every write plus primed/rdaddr per cycle.
module tb_mlab_sr_writer;
    import mlab_sr_pkg::*;

    logic clk;
    logic arst_n;
    int   pass_cnt;
    int   total_cnt;

    mlab_sr_writer_if bus_if ();

    mlab_sr_writer dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired before the end of the stimulus");
        $fatal(1, "watchdog");
    end

    // model state: words accepted, latched delay, fill progress
    logic [24:0]           exp_q[$];     // {addr, stored word}
    logic [5:0]            st_q[$];      // {primed, rdaddr}
    logic [ADDR_WIDTH-1:0] m_wp;
    logic [ADDR_WIDTH-1:0] m_dq;
    logic [ADDR_WIDTH-1:0] m_rd;
    int                    m_cnt;
    bit                    m_primed;
    logic [24:0]           stor_reg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_wp = '0; m_dq = 5'd1; m_rd = '0; m_cnt = 0; m_primed = 1'b0;
        exp_q.delete();
        st_q.delete();
    endtask

    function automatic logic [WORD_WIDTH-1:0] stored_word(input logic [PAY_WIDTH-1:0] d, input bit inj);
        logic par;
        // parity chosen so the 20-bit word has an odd number of ones
        par = ($countones(d) % 2 == 0);
`ifdef PARITY_INJECT_EN
        if (inj) par = ~par;
`endif
        return {par, d};
    endfunction

    // driver: one clock cycle of stimulus, model advanced at the edge
    task automatic drive(input bit en, input bit v, input logic [PAY_WIDTH-1:0] d,
                         input bit ld, input logic [4:0] dl, input bit inj);
        int target;
        bit new_primed;
        logic [ADDR_WIDTH-1:0] new_rd;
        bus_if.ena        = en;
        bus_if.din_valid  = v;
        bus_if.din        = d;
        bus_if.delay_load = ld;
        bus_if.delay      = dl;
`ifdef PARITY_INJECT_EN
        bus_if.inject_err = inj;
`endif
        @(posedge clk);
        if (en) begin
            target     = (int'(m_dq) + 2 > 31) ? 31 : int'(m_dq) + 2;
            new_rd     = m_wp - m_dq;
            new_primed = ld ? 1'b0 : (m_primed || m_cnt >= target);
            if (v) begin
                exp_q.push_back({m_wp, stored_word(d, inj)});
                m_wp = m_wp + 1'b1;
            end
            m_cnt = ld ? int'(v) : m_cnt + int'(v);
            if (ld) m_dq = (dl == 0) ? 5'd1 : dl;
            m_primed = new_primed;
            m_rd     = new_rd;
        end
        st_q.push_back({m_primed, m_rd});
        #1;
    endtask

    task automatic word(input logic [PAY_WIDTH-1:0] d);
        drive(1'b1, 1'b1, d, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, 1'b0, 5'd0, 1'b0);
    endtask

    // monitor: storage input register model and per-cycle status check
    always @(negedge clk) begin
        logic [24:0] e;
        logic [5:0]  s;
        if (!arst_n) begin
            stor_reg = '0;
        end else begin
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                chk("primed", 32'(bus_if.primed), 32'(s[5]));
                chk("rdaddr", 32'(bus_if.mlab_rdaddr), 32'(s[4:0]));
            end
            if (bus_if.ena) begin
                if (bus_if.mlab_we) begin
                    if (exp_q.size() == 0) begin
                        chk("we_without_word", 32'(bus_if.mlab_we), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("write_addr", 32'(stor_reg[24:20]), 32'(e[24:20]));
                        chk("write_data", 32'(stor_reg[19:0]), 32'(e[19:0]));
                    end
                end
                stor_reg = {bus_if.mlab_wraddr, bus_if.mlab_din};
            end
        end
    end

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        model_reset();
        stor_reg = '0;
        arst_n = 1'b0;
        bus_if.ena = 1'b0; bus_if.din_valid = 1'b0; bus_if.din = '0;
        bus_if.delay_load = 1'b0; bus_if.delay = '0;
`ifdef PARITY_INJECT_EN
        bus_if.inject_err = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        chk("reset_mlab_din", 32'(bus_if.mlab_din), 32'd0);
        chk("reset_wraddr", 32'(bus_if.mlab_wraddr), 32'd0);
        chk("reset_we", 32'(bus_if.mlab_we), 32'd0);
        chk("reset_rdaddr", 32'(bus_if.mlab_rdaddr), 32'd0);
        chk("reset_primed", 32'(bus_if.primed), 32'd0);
        arst_n = 1'b1;

        // delay 4, seven consecutive words
        drive(1'b1, 1'b0, '0, 1'b1, 5'd4, 1'b0);
        for (int i = 1; i <= 7; i++) word(PAY_WIDTH'(i));
        idle(2);

        // parity extremes
        word(19'h7FFFF);
        word(19'h00000);
        idle(2);

        // delay 31, 40 words across the wrap
        drive(1'b1, 1'b0, '0, 1'b1, 5'd31, 1'b0);
        for (int i = 0; i < 40; i++) word(PAY_WIDTH'($urandom_range(0, 19'h7FFFF)));

        // ena low for three cycles mid-stream, inputs toggling meanwhile
        word(19'h12345);
        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b1, PAY_WIDTH'($urandom), 1'b1, 5'($urandom), 1'b0);
        word(19'h54321);
        idle(2);

        // reach RUN with delay 8, then reload with delay 0 alongside a word
        drive(1'b1, 1'b0, '0, 1'b1, 5'd8, 1'b0);
        for (int i = 0; i < 12; i++) word(PAY_WIDTH'($urandom_range(0, 19'h7FFFF)));
        drive(1'b1, 1'b1, 19'h0AAAA, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) word(PAY_WIDTH'($urandom_range(0, 19'h7FFFF)));

        // parity inject on one word, neighbour normal
        drive(1'b1, 1'b1, 19'h00003, 1'b0, 5'd0, 1'b1);
        word(19'h00003);
        idle(2);

        // random traffic with gaps, ena drops and reloads
        for (int i = 0; i < 300; i++)
            drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                  PAY_WIDTH'($urandom), ($urandom_range(0, 24) == 0),
                  5'($urandom), 1'($urandom_range(0, 7) == 0));

        // reset in the middle of a burst
        for (int i = 0; i < 3; i++) word(PAY_WIDTH'(i + 100));
        #2;
        arst_n = 1'b0;
        #1;
        chk("midreset_we", 32'(bus_if.mlab_we), 32'd0);
        chk("midreset_din", 32'(bus_if.mlab_din), 32'd0);
        chk("midreset_wraddr", 32'(bus_if.mlab_wraddr), 32'd0);
        model_reset();
        bus_if.ena = 1'b0;
        @(negedge clk);
        #2;
        arst_n = 1'b1;
        drive(1'b1, 1'b0, '0, 1'b1, 5'd2, 1'b0);
        for (int i = 0; i < 6; i++) word(PAY_WIDTH'($urandom_range(0, 19'h7FFFF)));
        idle(4);
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
